// File: rtl/jtag_reg_bridge_if.sv
// Request/response bus between the JTAG bridge and the on-chip register target.
// The bridge issues one request at a time; read data returns as a single-cycle pulse.
interface jtag_reg_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/jtag_reg_bridge.sv
// JTAG user-DR to register-bus bridge: tap signals are oversampled in clk, and each
// Update-DR becomes one read or write on the request port.
module jtag_reg_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic jtag_tck,
  input  logic jtag_sel,
  input  logic jtag_shift,
  input  logic jtag_capture,
  input  logic jtag_update,
  input  logic jtag_treset,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  jtag_reg_bridge_if.master bus
);

  localparam int DR_W = DATA_W + ADDR_W + 1;
  localparam int NTAP = 7;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dr_t;

  logic [NTAP-1:0]                  tap_raw;
  logic [SYNC_STAGES-1:0][NTAP-1:0] sync_q;
  logic [NTAP-1:0]                  tap_s;
  logic                             tck_d, upd_d;

  logic tck_s, sel_s, shift_s, cap_s, upd_s, tdi_s, trst_s;
  logic tck_rise, tck_fall, upd_rise, capture_ev, shift_ev;

  state_t            state;
  logic [DR_W-1:0]   sr;
  dr_t               sr_f;
  logic [DATA_W-1:0] rdata_hold;
  logic              overrun;
  logic              busy;
  logic [ADDR_W-1:0] status;

  logic              req_valid_q, req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  assign tap_raw = {jtag_treset, jtag_tdi, jtag_update, jtag_capture,
                    jtag_shift, jtag_sel, jtag_tck};

  // Newest sample enters at index 0; the last stage is the synchronised value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      tck_d  <= 1'b0;
      upd_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tap_raw};
      tck_d  <= tck_s;
      upd_d  <= upd_s;
    end
  end

  assign tap_s   = sync_q[SYNC_STAGES-1];
  assign tck_s   = tap_s[0];
  assign sel_s   = tap_s[1];
  assign shift_s = tap_s[2];
  assign cap_s   = tap_s[3];
  assign upd_s   = tap_s[4];
  assign tdi_s   = tap_s[5];
  assign trst_s  = tap_s[6];

  assign tck_rise   = sel_s &  tck_s & ~tck_d;
  assign tck_fall   = sel_s & ~tck_s &  tck_d;
  assign upd_rise   = sel_s &  upd_s & ~upd_d;
  assign capture_ev = tck_rise & cap_s;
  assign shift_ev   = tck_rise & shift_s & ~cap_s;

  assign busy = (state != IDLE);
  assign sr_f = dr_t'(sr);

  // Address field bits [1:0] carry status on capture; upper bits read as zero.
  always_comb begin
    status    = '0;
    status[1] = overrun;
    status[0] = busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      jtag_tdo    <= 1'b0;
      overrun     <= 1'b0;
      rdata_hold  <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      if (trst_s) begin
        sr       <= '0;
        jtag_tdo <= 1'b0;
      end else begin
        if (capture_ev)
          sr <= {1'b0, status, rdata_hold};
        else if (shift_ev)
          sr <= {tdi_s, sr[DR_W-1:1]};
        if (tck_fall)
          jtag_tdo <= sr[0];
      end

      // A dropped update outranks a coincident read-to-clear capture.
      if (trst_s)
        overrun <= 1'b0;
      else if (upd_rise && state != IDLE)
        overrun <= 1'b1;
      else if (capture_ev)
        overrun <= 1'b0;

      // Treset deliberately leaves the transaction machinery alone.
      case (state)
        IDLE: begin
          if (upd_rise) begin
            req_we_q    <= sr_f.we;
            req_addr_q  <= sr_f.addr;
            req_wdata_q <= sr_f.data;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            state       <= req_we_q ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.rsp_valid) begin
            rdata_hold <= bus.rsp_rdata;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.req_we    = req_we_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Scoreboarded bench for jtag_reg_bridge: a host task drives tap scans, a target model
// answers the bus, and a monitor pairs observed requests/scan-outs with model predictions.
module tb_jtag_reg_bridge;
  localparam int DATA_W = 32, ADDR_W = 8, SYNC_STAGES = 2;
  localparam int DR_W = DATA_W + ADDR_W + 1;
  localparam int HALF = 6;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic jtag_tck = 0, jtag_sel = 0, jtag_shift = 0, jtag_capture = 0;
  logic jtag_update = 0, jtag_treset = 0, jtag_tdi = 0;
  logic jtag_tdo;

  jtag_reg_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  jtag_reg_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset),
    .jtag_tck(jtag_tck), .jtag_sel(jtag_sel), .jtag_shift(jtag_shift),
    .jtag_capture(jtag_capture), .jtag_update(jtag_update),
    .jtag_treset(jtag_treset), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .bus(bus)
  );

  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } req_t;

  int checks = 0, passes = 0;
  req_t            exp_req[$];
  logic [DR_W-1:0] exp_cap[$], obs_cap[$];

  // Reference model state: register file seen by the host, overrun flag, last read data.
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] tgt_mem [logic [ADDR_W-1:0]];
  bit                m_ov = 0;
  logic [DATA_W-1:0] m_rdata = '0;

  int rdy_mode = 0, fixed_delay = 0, rsp_cnt = 0, run_len = 0, last_len = 0;
  logic [DATA_W-1:0] rsp_buf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return DATA_W'({24'h13579B, a});
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DR_W-1:0] cap_word(input bit busy);
    logic [ADDR_W-1:0] st;
    st = '0;
    st[1] = m_ov;
    st[0] = busy;
    return {1'b0, st, m_rdata};
  endfunction

  // Register target: random or forced ready, read data returned after a delay.
  initial begin
    bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin bus.rsp_valid = 1; bus.rsp_rdata = rsp_buf; end
      end
      case (rdy_mode)
        1:       bus.req_ready = 1;
        2:       bus.req_ready = 0;
        default: bus.req_ready = 1'($urandom % 2);
      endcase
      if (!reset && bus.req_valid && bus.req_ready) begin
        if (bus.req_we) tgt_mem[bus.req_addr] = bus.req_wdata;
        else begin
          rsp_buf = tgt_mem.exists(bus.req_addr) ? tgt_mem[bus.req_addr] : init_val(bus.req_addr);
          rsp_cnt = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
        end
      end
    end
  end

  // Monitor: pairs DUT activity with the queued predictions.
  initial begin
    bit pend = 0;
    logic [DR_W-1:0] prev_req = '0;
    logic tdo_prev = 0;
    req_t e;
    logic [DR_W-1:0] o, x;
    forever begin
      @(negedge clk); #2;
      if (!reset && bus.req_valid && bus.req_ready) begin
        chk("req_expected", 64'(exp_req.size() > 0), 64'(1));
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          chk("req_we", 64'(bus.req_we), 64'(e.we));
          chk("req_addr", 64'(bus.req_addr), 64'(e.addr));
          chk("req_wdata", 64'(bus.req_wdata), 64'(e.data));
        end
      end
      if (pend && !reset) begin
        chk("req_hold_valid", 64'(bus.req_valid), 64'(1));
        chk("req_hold_fields", 64'({bus.req_we, bus.req_addr, bus.req_wdata}), 64'(prev_req));
      end
      pend = !reset && bus.req_valid && !bus.req_ready;
      prev_req = {bus.req_we, bus.req_addr, bus.req_wdata};
      if (jtag_tdo !== tdo_prev) chk("tdo_change_tck_low", 64'(jtag_tck), 64'(0));
      tdo_prev = jtag_tdo;
      if (bus.req_valid) run_len++;
      else if (run_len > 0) begin last_len = run_len; run_len = 0; end
      if (obs_cap.size() > 0 && exp_cap.size() > 0) begin
        o = obs_cap.pop_front();
        x = exp_cap.pop_front();
        chk("scan_out", 64'(o), 64'(x));
      end
    end
  end

  task automatic scan(input logic [DR_W-1:0] din, input bit cap, input bit upd,
                      output logic [DR_W-1:0] dout);
    dout = '0;
    if (cap) begin
      jtag_capture = 1; wclk(HALF);
      jtag_tck = 1;     wclk(HALF);
      jtag_tck = 0;     wclk(HALF);
      jtag_capture = 0;
    end
    jtag_shift = 1;
    for (int i = 0; i < DR_W; i++) begin
      jtag_tdi = din[i]; wclk(HALF);
      dout[i] = jtag_tdo;
      jtag_tck = 1; wclk(HALF);
      jtag_tck = 0;
    end
    wclk(HALF);
    jtag_shift = 0;
    if (upd) begin
      jtag_update = 1; wclk(HALF);
      jtag_update = 0; wclk(HALF);
    end
  endtask

  // Capture status, shift in a command, update; the DUT is expected idle on entry.
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int settle);
    logic [DR_W-1:0] dout;
    req_t r;
    exp_cap.push_back(cap_word(0));
    m_ov = 0;
    r.we = we; r.addr = a; r.data = d;
    exp_req.push_back(r);
    if (we) ref_mem[a] = d;
    else m_rdata = ref_rd(a);
    scan({we, a, d}, 1, 1, dout);
    obs_cap.push_back(dout);
    wclk(settle);
  endtask

  task automatic status_scan(input bit busy, input logic [DR_W-1:0] din, input bit upd);
    logic [DR_W-1:0] dout;
    exp_cap.push_back(cap_word(busy));
    m_ov = 0;
    scan(din, 1, upd, dout);
    obs_cap.push_back(dout);
  endtask

  task automatic shift_only(input logic [DR_W-1:0] din, input logic [DR_W-1:0] expect_out);
    logic [DR_W-1:0] dout;
    exp_cap.push_back(expect_out);
    scan(din, 0, 0, dout);
    obs_cap.push_back(dout);
  endtask

  initial begin
    logic [DR_W-1:0] c;
    req_t r;
    bit seen;

    wclk(5);
    reset = 0;
    wclk(3);
    chk("rst_req_valid", 64'(bus.req_valid), 64'(0));
    chk("rst_req_we", 64'(bus.req_we), 64'(0));
    chk("rst_req_addr", 64'(bus.req_addr), 64'(0));
    chk("rst_req_wdata", 64'(bus.req_wdata), 64'(0));
    chk("rst_tdo", 64'(jtag_tdo), 64'(0));
    jtag_sel = 1;
    wclk(4);

    // Directed write with ready tied high: single-cycle request.
    rdy_mode = 1; last_len = 0;
    host_op(1, 8'h12, 32'hDEADBEEF, 60);
    chk("write_valid_len", 64'(last_len), 64'(1));

    // Directed read, response 3 clk after handshake.
    ref_mem[8'h05] = 32'hCAFEF00D; tgt_mem[8'h05] = 32'hCAFEF00D;
    fixed_delay = 3;
    host_op(0, 8'h05, $urandom, 60);
    fixed_delay = 0; rdy_mode = 0;

    for (int k = 0; k < 20; k++)
      host_op(1'($urandom % 2), ADDR_W'($urandom_range(0, 15)), $urandom, 60);

    // Backpressure and overrun.
    rdy_mode = 2;
    exp_cap.push_back(cap_word(0)); m_ov = 0;
    r.we = 1; r.addr = 8'h33; r.data = $urandom;
    exp_req.push_back(r); ref_mem[r.addr] = r.data;
    scan({r.we, r.addr, r.data}, 1, 1, c); obs_cap.push_back(c);
    wclk(20);
    status_scan(1, {1'b1, 8'h44, 32'h1111_2222}, 1);
    m_ov = 1;
    status_scan(1, '0, 0);
    status_scan(1, '0, 0);
    rdy_mode = 0;
    wclk(60);

    // TDO follows sr[0]: preload 0xA, then shift 0x5 through.
    status_scan(0, DR_W'(4'hA), 0);
    shift_only(DR_W'(4'h5), DR_W'(4'hA));
    shift_only('0, DR_W'(4'h5));

    // Treset while a read waits for its response.
    rdy_mode = 1; fixed_delay = 200;
    host_op(0, 8'h07, $urandom, 15);
    jtag_treset = 1; wclk(8);
    chk("treset_tdo", 64'(jtag_tdo), 64'(0));
    jtag_treset = 0; m_ov = 0; wclk(5);
    shift_only('0, '0);
    fixed_delay = 0; rdy_mode = 0;
    wclk(20);

    // sel=0: tap activity must be ignored.
    c = {1'b0, ADDR_W'($urandom), DATA_W'($urandom)};
    status_scan(0, c, 0);
    jtag_sel = 0; wclk(4);
    jtag_shift = 1; jtag_tdi = 1;
    for (int k = 0; k < 4; k++) begin jtag_tck = 1; wclk(HALF); jtag_tck = 0; wclk(HALF); end
    jtag_shift = 0; jtag_capture = 1;
    jtag_tck = 1; wclk(HALF); jtag_tck = 0; wclk(HALF);
    jtag_capture = 0; jtag_update = 1; wclk(HALF); jtag_update = 0; wclk(HALF);
    chk("sel0_no_req", 64'(bus.req_valid), 64'(0));
    jtag_sel = 1; wclk(4);
    shift_only('0, c);

    // Synchronous reset while a request is pending.
    rdy_mode = 2;
    status_scan(0, {1'b1, 8'h55, 32'h0BAD_F00D}, 1);
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (bus.req_valid) seen = 1; else wclk(1);
    end
    chk("req_pending_before_reset", 64'(seen), 64'(1));
    reset = 1; wclk(1);
    reset = 0;
    chk("reset_drops_valid", 64'(bus.req_valid), 64'(0));
    m_ov = 0; m_rdata = '0; rdy_mode = 0;
    wclk(10);
    status_scan(0, '0, 0);

    wclk(20);
    chk("req_queue_drained", 64'(exp_req.size()), 64'(0));
    chk("scan_queue_drained", 64'(exp_cap.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
